sel_skid_reg: RTL and testbench

- Parametrised successor to the pipeline's 2:1 select. Chooses one of CH input channels, each W bits wide, and registers the result.
- The registered result passes through a 2-entry skid buffer with a valid/ready handshake and a synchronous flush.
- Used between pipeline stages (forwarding/operand select into EX, PC-source select into IF) so that stalls and flushes are absorbed without combinational ready paths.

---
 rtl/sel_skid_if.sv | 30 +++
 rtl/sel_skid_reg.sv | 103 ++++++++++
 tb/tb_sel_skid_reg.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sel_skid_if.sv
// sel_skid_if: handshake bundle for sel_skid_reg.
// Upstream side: in_data (CH packed channels of W bits), sel, in_valid, in_ready, flush.
// Downstream side: out_data, out_sel, out_valid, out_ready.
// Status: sel_err (bad select seen), stall_cnt (stall statistic).
// master = the side that drives the block, slave = the block itself.
interface sel_skid_if #(
    parameter int W  = 32,
    parameter int CH = 4
);
    localparam int SEL_W = $clog2(CH);
    logic [CH*W-1:0]  in_data;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;
    logic [15:0]      stall_cnt;
    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_valid, sel_err, stall_cnt
    );
    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_valid, sel_err, stall_cnt
    );
endinterface

// File: rtl/sel_skid_reg.sv
// sel_skid_reg: CH:1 registered select feeding a 2-entry skid buffer with valid/ready and flush.
// Ports: clk (rising edge), rst (async, active high), bus (sel_skid_if.slave):
//   in_data/sel/in_valid/in_ready upstream handshake, flush sync kill,
//   out_data/out_sel/out_valid/out_ready downstream handshake,
//   sel_err one-cycle pulse after accepting sel >= CH, stall_cnt stall statistic.
// Optional: define SEL_SKID_STALL_CNT_EN to build the saturating stall counter;
//   otherwise stall_cnt is tied to zero.
module sel_skid_reg #(
    parameter  int W     = 32,
    parameter  int CH    = 4,
    localparam int SEL_W = $clog2(CH)
) (
    input logic       clk,
    input logic       rst,
    sel_skid_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    localparam logic [SEL_W:0] CH_L = (SEL_W + 1)'(CH);
    state_t           state_q, state_d;
    logic [W-1:0]     main_data, skid_data, pick;
    logic [SEL_W-1:0] main_sel, skid_sel, pick_sel;
    logic             in_ready_q, sel_err_q, out_valid;
    logic             accept, pop, bad, load_main, load_skid, promote;
    // out-of-range selects fall back to channel 0 and are reported via sel_err
    assign bad       = {1'b0, bus.sel} >= CH_L;
    assign pick_sel  = bad ? '0 : bus.sel;
    assign out_valid = state_q != EMPTY;
    assign accept    = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;
    always_comb begin
        pick = bus.in_data[W-1:0];
        for (int k = 1; k < CH; k++)
            pick = (bus.sel == SEL_W'(k)) ? bus.in_data[k*W +: W] : pick;
    end
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        if (bus.flush)
            state_d = EMPTY;
        else
            case (state_q)
                EMPTY: begin
                    load_main = accept;
                    state_d   = accept ? ONE : EMPTY;
                end
                ONE: begin
                    load_main = accept & pop;
                    load_skid = accept & ~pop;
                    state_d   = load_skid ? TWO : (pop & ~accept) ? EMPTY : ONE;
                end
                TWO: begin
                    promote = pop;
                    state_d = pop ? ONE : TWO;
                end
                default: state_d = EMPTY;
            endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    // in_ready is registered from the next state so no combinational path reaches upstream
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            in_ready_q <= 1'b1;
            sel_err_q  <= 1'b0;
            main_data  <= '0;
            main_sel   <= '0;
            skid_data  <= '0;
            skid_sel   <= '0;
        end else begin
            in_ready_q <= state_d != TWO;
            sel_err_q  <= ~bus.flush & accept & bad;
            if (load_main) begin
                main_data <= pick;
                main_sel  <= pick_sel;
            end else if (promote) begin
                main_data <= skid_data;
                main_sel  <= skid_sel;
            end
            if (load_skid) begin
                skid_data <= pick;
                skid_sel  <= pick_sel;
            end
        end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data;
    assign bus.out_sel   = main_sel;
    assign bus.sel_err   = sel_err_q;
`ifdef SEL_SKID_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            stall_q <= '0;
        else if (out_valid & ~bus.out_ready & (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_sel_skid_reg.sv
// tb_sel_skid_reg: directed and random checks of sel_skid_reg against a queue model.
module tb_sel_skid_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sel_skid_if #(.W(32), .CH(4)) b4 ();
    sel_skid_if #(.W(32), .CH(3)) b3 ();
    sel_skid_reg #(.W(32), .CH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    sel_skid_reg #(.W(32), .CH(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;
    ent_t        q[$];
    logic        exp_err;
    int unsigned exp_stall;
    int          passes = 0;
    int          fails  = 0;
    int          total  = 0;

`ifdef SEL_SKID_STALL_CNT_EN
    localparam logic [31:0] STALL10 = 32'd10;
`else
    localparam logic [31:0] STALL10 = 32'd0;
`endif

    function automatic logic [31:0] stall_exp();
`ifdef SEL_SKID_STALL_CNT_EN
        return exp_stall;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [127:0] pk(input logic [31:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(b4.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", b4.out_data, q[0].d);
            chk("out_sel", 32'(b4.out_sel), 32'(q[0].s));
        end
        chk("in_ready", 32'(b4.in_ready), 32'(q.size() < 2));
        chk("sel_err", 32'(b4.sel_err), 32'(exp_err));
        chk("stall_cnt", 32'(b4.stall_cnt), stall_exp());
    endtask

    // one clock cycle: drive, check outputs mid-cycle, advance model, clock
    task automatic step(input logic iv, input logic [1:0] s, input logic [127:0] d,
                        input logic ordy, input logic fl);
        logic acc, pp;
        b4.in_valid  = iv;
        b4.sel       = s;
        b4.in_data   = d;
        b4.out_ready = ordy;
        b4.flush     = fl;
        #2;
        check_model();
        acc = iv && (q.size() < 2);
        pp  = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy && exp_stall < 32'hFFFF) exp_stall++;
        exp_err = 1'b0;
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back('{d[s*32 +: 32], s});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_ready", 32'(b4.in_ready), 32'd1);
        chk("rst_data", b4.out_data, 32'd0);
        chk("rst_stall", 32'(b4.stall_cnt), 32'd0);
        q.delete();
        exp_err   = 1'b0;
        exp_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        b4.in_valid = 0; b4.sel = 0; b4.in_data = '0; b4.out_ready = 0; b4.flush = 0;
        b3.in_valid = 0; b3.sel = 0; b3.in_data = '0; b3.out_ready = 1; b3.flush = 0;
        exp_err = 0;
        exp_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(b4.out_valid), 32'd0);
        chk("reset_data", b4.out_data, 32'd0);
        chk("reset_sel", 32'(b4.out_sel), 32'd0);
        chk("reset_ready", 32'(b4.in_ready), 32'd1);
        chk("reset_err", 32'(b4.sel_err), 32'd0);
        chk("reset_stall", 32'(b4.stall_cnt), 32'd0);
        rst = 1'b0;

        // single transfer
        step(1, 2, pk(32'h0, 32'h0, 32'hDEADBEEF, 32'h0), 1, 0);
        chk("t1_valid", 32'(b4.out_valid), 32'd1);
        chk("t1_data", b4.out_data, 32'hDEADBEEF);
        chk("t1_sel", 32'(b4.out_sel), 32'd2);
        step(0, 0, '0, 1, 0);
        chk("t1_gone", 32'(b4.out_valid), 32'd0);

        // backpressure fill and drain
        step(1, 0, pk(32'h11, 32'h0, 32'h0, 32'h0), 0, 0);
        step(1, 1, pk(32'h0, 32'h22, 32'h0, 32'h0), 0, 0);
        chk("bp_ready", 32'(b4.in_ready), 32'd0);
        chk("bp_hold", b4.out_data, 32'h11);
        step(1, 2, pk(32'h0, 32'h0, 32'h33, 32'h0), 0, 0);
        chk("bp_still", b4.out_data, 32'h11);
        step(0, 0, '0, 1, 0);
        chk("bp_second", b4.out_data, 32'h22);
        chk("bp_ready2", 32'(b4.in_ready), 32'd1);
        step(0, 0, '0, 1, 0);
        chk("bp_empty", 32'(b4.out_valid), 32'd0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            d[(i % 4)*32 +: 32] = 32'(i + 1);
            step(1, 2'(i % 4), d, 1, 0);
            chk("stream_ready", 32'(b4.in_ready), 32'd1);
            chk("stream_data", b4.out_data, 32'(i + 1));
        end
        step(0, 0, '0, 1, 0);

        // flush in TWO, with in_valid high
        step(1, 0, pk(32'hA, 32'h0, 32'h0, 32'h0), 0, 0);
        step(1, 0, pk(32'hB, 32'h0, 32'h0, 32'h0), 0, 0);
        step(1, 0, pk(32'hC, 32'h0, 32'h0, 32'h0), 0, 1);
        chk("flush_valid", 32'(b4.out_valid), 32'd0);
        chk("flush_ready", 32'(b4.in_ready), 32'd1);
        step(0, 0, '0, 1, 0);
        chk("flush_quiet", 32'(b4.out_valid), 32'd0);
        // flush beats a simultaneous accept and pop in ONE
        step(1, 0, pk(32'hA, 32'h0, 32'h0, 32'h0), 0, 0);
        step(1, 1, pk(32'h0, 32'hD, 32'h0, 32'h0), 1, 1);
        chk("flush_one", 32'(b4.out_valid), 32'd0);
        step(0, 0, '0, 1, 0);

        // reset in the middle of a full buffer
        step(1, 0, pk(32'h1, 32'h0, 32'h0, 32'h0), 0, 0);
        step(1, 0, pk(32'h2, 32'h0, 32'h0, 32'h0), 0, 0);
        reset_mid();

        // stall statistic
        step(1, 0, pk(32'h7, 32'h0, 32'h0, 32'h0), 0, 0);
        repeat (10) step(0, 0, '0, 0, 0);
        chk("stall_10", 32'(b4.stall_cnt), STALL10);
        step(0, 0, '0, 1, 1);
        chk("stall_flush", 32'(b4.stall_cnt), STALL10);

        // bad select on the 3-channel instance
        b3.in_data = {32'h7, 32'h6, 32'h5};
        b3.sel = 3;
        b3.in_valid = 1;
        step(0, 0, '0, 1, 0);
        b3.in_valid = 0;
        chk("bad_data", b3.out_data, 32'h5);
        chk("bad_err", 32'(b3.sel_err), 32'd1);
        chk("bad_valid", 32'(b3.out_valid), 32'd1);
        step(0, 0, '0, 1, 0);
        chk("bad_err_off", 32'(b3.sel_err), 32'd0);
        b3.sel = 2;
        b3.in_valid = 1;
        step(0, 0, '0, 1, 0);
        b3.in_valid = 0;
        chk("good_data", b3.out_data, 32'h7);
        chk("good_sel", 32'(b3.out_sel), 32'd2);
        chk("good_err", 32'(b3.sel_err), 32'd0);
        step(0, 0, '0, 1, 0);

        // random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_mid();
            step($urandom_range(99) < 70, 2'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(99) < 60, $urandom_range(99) < 4);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
